alu_pipe: RTL and testbench

Parametrised, pipelined successor to the team's 8-bit combinational ALU.
- WIDTH-bit operands; 16-entry opcode space.
- Adds carry-chained ADC/SBC, rotates, arithmetic shift right, compare, and a signed overflow flag.
- Valid/ready handshake on both sides, 2-cycle latency, 1 op/cycle throughput.
- Sits between the operand-fetch stage and result writeback of the datapath.

---
 rtl/alu_pipe_pkg.sv | 33 +++
 rtl/alu_pipe_core.sv | 85 ++++++++
 rtl/alu_pipe.sv | 97 +++++++++
 tb/tb_alu_pipe.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pipe_pkg.sv
// Shared types for the pipelined ALU: opcode encoding and result flag bundle.
package alu_pipe_pkg;

  localparam int OP_W = 4;

  typedef enum logic [OP_W-1:0] {
    OP_ADD   = 4'h0,
    OP_SUB   = 4'h1,
    OP_AND   = 4'h2,
    OP_OR    = 4'h3,
    OP_XOR   = 4'h4,
    OP_NOT   = 4'h5,
    OP_SHL   = 4'h6,
    OP_SHR   = 4'h7,
    OP_ADC   = 4'h8,
    OP_SBC   = 4'h9,
    OP_ROL   = 4'hA,
    OP_ROR   = 4'hB,
    OP_ASR   = 4'hC,
    OP_CMP   = 4'hD,
    OP_PASSB = 4'hE,
    OP_ILL   = 4'hF
  } alu_op_e;

  typedef struct packed {
    logic carry;
    logic negative;
    logic zero;
    logic overflow;
    logic illegal;
  } alu_flags_t;

endpackage

// File: rtl/alu_pipe_core.sv
// Combinational ALU datapath: one shared (WIDTH+1)-bit adder and subtractor,
// shifts/rotates, and flag generation.
module alu_core
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  alu_op_e          i_op,
  input  logic             i_cin,
  output logic [WIDTH-1:0] o_result,
  output alu_flags_t       o_flags
);

  localparam int MSB = WIDTH - 1;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic             w_add_cin;
  logic             w_sub_bin;
  logic             w_add_ov;
  logic             w_sub_ov;
  logic [WIDTH-1:0] w_nz;

  // Carry-in only for ADC; SBC borrows when the previous carry is clear.
  assign w_add_cin = (i_op == OP_ADC) && i_cin;
  assign w_sub_bin = (i_op == OP_SBC) && !i_cin;

  assign w_sum  = {1'b0, i_a} + {1'b0, i_b} + {{WIDTH{1'b0}}, w_add_cin};
  assign w_diff = {1'b0, i_a} - {1'b0, i_b} - {{WIDTH{1'b0}}, w_sub_bin};

  assign w_add_ov = (i_a[MSB] == i_b[MSB]) && (w_sum[MSB]  != i_a[MSB]);
  assign w_sub_ov = (i_a[MSB] != i_b[MSB]) && (w_diff[MSB] != i_a[MSB]);

  always_comb begin
    o_result = '0;
    o_flags  = '0;
    w_nz     = '0;
    case (i_op)
      OP_ADD, OP_ADC: begin
        o_result         = w_sum[MSB:0];
        o_flags.carry    = w_sum[WIDTH];
        o_flags.overflow = w_add_ov;
      end
      OP_SUB, OP_SBC, OP_CMP: begin
        o_result         = (i_op == OP_CMP) ? i_a : w_diff[MSB:0];
        o_flags.carry    = ~w_diff[WIDTH];
        o_flags.overflow = w_sub_ov;
      end
      OP_AND:   o_result = i_a & i_b;
      OP_OR:    o_result = i_a | i_b;
      OP_XOR:   o_result = i_a ^ i_b;
      OP_NOT:   o_result = ~i_a;
      OP_SHL: begin
        o_result      = {i_a[MSB-1:0], 1'b0};
        o_flags.carry = i_a[MSB];
      end
      OP_SHR: begin
        o_result      = {1'b0, i_a[MSB:1]};
        o_flags.carry = i_a[0];
      end
      OP_ROL: begin
        o_result      = {i_a[MSB-1:0], i_a[MSB]};
        o_flags.carry = i_a[MSB];
      end
      OP_ROR: begin
        o_result      = {i_a[0], i_a[MSB:1]};
        o_flags.carry = i_a[0];
      end
      OP_ASR: begin
        o_result      = {i_a[MSB], i_a[MSB:1]};
        o_flags.carry = i_a[0];
      end
      OP_PASSB: o_result = i_b;
      OP_ILL:   o_flags.illegal = 1'b1;
      default:  o_result = '0;
    endcase
    // CMP reports N/Z of the difference while passing A through unchanged.
    w_nz             = (i_op == OP_CMP) ? w_diff[MSB:0] : o_result;
    o_flags.negative = w_nz[MSB];
    o_flags.zero     = (w_nz == '0);
  end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU pipeline: operand register, combinational compute,
// output register. Owns the running carry used by ADC/SBC.
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [OP_W-1:0]  in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_carry,
  output logic             out_negative,
  output logic             out_zero,
  output logic             out_overflow,
  output logic             out_illegal
);

  logic             r_s0_valid;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  alu_op_e          r_op;
  logic             r_cflag;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  alu_flags_t       r_flags;

  logic             w_adv;
  logic             w_accept;
  logic             w_xfer;
  logic [WIDTH-1:0] w_result;
  alu_flags_t       w_flags;

  assign w_adv    = !r_out_valid || out_ready;
  assign in_ready = !r_s0_valid || w_adv;
  assign w_accept = in_valid && in_ready;
  assign w_xfer   = r_s0_valid && w_adv;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .i_a      (r_a),
    .i_b      (r_b),
    .i_op     (r_op),
    .i_cin    (r_cflag),
    .o_result (w_result),
    .o_flags  (w_flags)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s0_valid  <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_op        <= OP_ADD;
      r_cflag     <= 1'b0;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_flags     <= '0;
    end else begin
      if (w_accept) begin
        r_a  <= in_a;
        r_b  <= in_b;
        r_op <= alu_op_e'(in_op);
      end

      if (w_accept)
        r_s0_valid <= 1'b1;
      else if (w_xfer)
        r_s0_valid <= 1'b0;

      // Carry advances in issue order; an illegal op leaves it untouched.
      if (w_xfer) begin
        r_out_valid <= 1'b1;
        r_result    <= w_result;
        r_flags     <= w_flags;
        if (!w_flags.illegal)
          r_cflag <= w_flags.carry;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid    = r_out_valid;
  assign out_result   = r_result;
  assign out_carry    = r_flags.carry;
  assign out_negative = r_flags.negative;
  assign out_zero     = r_flags.zero;
  assign out_overflow = r_flags.overflow;
  assign out_illegal  = r_flags.illegal;

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboarded bench for alu_pipe at WIDTH=8 and WIDTH=16 with an arithmetic reference model.
module tb_alu_pipe;

  typedef struct {
    longint res;
    bit c, n, z, v, il;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst8 = 1'b1, iv8 = 1'b0, ir8, ov8, or8 = 1'b1;
  logic [7:0]  a8 = '0, b8 = '0, res8;
  logic [3:0]  op8 = '0;
  logic        c8, n8, z8, v8, il8;

  logic        rst16 = 1'b1, iv16 = 1'b0, ir16, ov16, or16 = 1'b1;
  logic [15:0] a16 = '0, b16 = '0, res16;
  logic [3:0]  op16 = '0;
  logic        c16, n16, z16, v16, il16;

  int   checks = 0;
  int   errors = 0;
  exp_t q8[$];
  exp_t q16[$];
  bit   cf8 = 0, cf16 = 0;
  bit   stall8 = 0, stall16 = 0, bp8 = 0, bp16 = 0;

  alu_pipe #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst8), .in_valid(iv8), .in_ready(ir8), .in_a(a8), .in_b(b8),
    .in_op(op8), .out_valid(ov8), .out_ready(or8), .out_result(res8),
    .out_carry(c8), .out_negative(n8), .out_zero(z8), .out_overflow(v8), .out_illegal(il8)
  );

  alu_pipe #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst16), .in_valid(iv16), .in_ready(ir16), .in_a(a16), .in_b(b16),
    .in_op(op16), .out_valid(ov16), .out_ready(or16), .out_result(res16),
    .out_carry(c16), .out_negative(n16), .out_zero(z16), .out_overflow(v16), .out_illegal(il16)
  );

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: operands as unsigned integers, signed view for overflow.
  function automatic exp_t model(input int w, input logic [3:0] op,
                                 input longint a, input longint b, input bit cin);
    exp_t   e;
    longint m, half, sa, sb, t, st, r, nzsrc;
    m = longint'(1) << w;
    half = m / 2;
    sa = (a >= half) ? a - m : a;
    sb = (b >= half) ? b - m : b;
    e.c = 0; e.v = 0; e.il = 0;
    r = 0; nzsrc = -1;
    case (op)
      4'h0, 4'h8: begin
        t  = a + b + ((op == 4'h8 && cin) ? 1 : 0);
        st = sa + sb + ((op == 4'h8 && cin) ? 1 : 0);
        r = t % m; e.c = (t >= m); e.v = (st < -half) || (st >= half);
      end
      4'h1, 4'h9, 4'hD: begin
        t  = a - b - ((op == 4'h9 && !cin) ? 1 : 0);
        st = sa - sb - ((op == 4'h9 && !cin) ? 1 : 0);
        r = (t + m) % m; e.c = (t >= 0); e.v = (st < -half) || (st >= half);
        if (op == 4'hD) begin nzsrc = r; r = a; end
      end
      4'h2: r = a & b;
      4'h3: r = a | b;
      4'h4: r = a ^ b;
      4'h5: r = m - 1 - a;
      4'h6: begin r = (a * 2) % m; e.c = (a >= half); end
      4'h7: begin r = a / 2; e.c = (a % 2 == 1); end
      4'hA: begin r = (a * 2) % m + ((a >= half) ? 1 : 0); e.c = (a >= half); end
      4'hB: begin r = a / 2 + (a % 2) * half; e.c = (a % 2 == 1); end
      4'hC: begin r = a / 2 + ((a >= half) ? half : 0); e.c = (a % 2 == 1); end
      4'hE: r = b;
      default: begin r = 0; e.il = 1; end
    endcase
    if (nzsrc < 0) nzsrc = r;
    e.res = r;
    e.n = (nzsrc >= half);
    e.z = (nzsrc == 0);
    return e;
  endfunction

  task automatic push(input int w, input logic [3:0] op, input longint a, input longint b,
                      input bit use_exp, input exp_t xe);
    exp_t e;
    e = model(w, op, a, b, (w == 8) ? cf8 : cf16);
    if (!e.il) begin
      if (w == 8) cf8 = e.c; else cf16 = e.c;
    end
    if (use_exp) e = xe;
    if (w == 8) q8.push_back(e); else q16.push_back(e);
  endtask

  task automatic issue(input int w, input logic [3:0] op, input longint a, input longint b,
                       input bit use_exp, input exp_t xe);
    int n;
    bit acc;
    n = 0; acc = 0;
    @(negedge clk);
    if (w == 8) begin iv8 = 1; op8 = op; a8 = a[7:0]; b8 = b[7:0]; end
    else begin iv16 = 1; op16 = op; a16 = a[15:0]; b16 = b[15:0]; end
    while (!acc && n <= 50) begin
      if ((w == 8) ? ir8 : ir16) acc = 1;
      else begin n++; @(negedge clk); end
    end
    if (!acc) chk("issue_timeout", 0, 1);
    else push(w, op, a, b, use_exp, xe);
    @(posedge clk);
    #1;
    if (w == 8) iv8 = 0; else iv16 = 0;
  endtask

  task automatic dir(input int w, input logic [3:0] op, input longint a, input longint b,
                     input longint res, input logic [4:0] fl);
    exp_t xe;
    xe.res = res;
    {xe.c, xe.n, xe.z, xe.v, xe.il} = fl;
    issue(w, op, a, b, 1'b1, xe);
  endtask

  task automatic drain(input int w);
    int n;
    n = 0;
    while (((w == 8) ? q8.size() : q16.size()) != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) chk("drain_timeout", 0, 1);
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    #1;
    or8  = stall8  ? 1'b0 : (bp8  ? ($urandom_range(0, 3) != 0) : 1'b1);
    or16 = stall16 ? 1'b0 : (bp16 ? ($urandom_range(0, 3) != 0) : 1'b1);
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst8 && ov8 && or8) begin
      if (q8.size() == 0) chk("w8_unexpected_out", 1, 0);
      else begin
        e = q8.pop_front();
        chk("w8_result", res8, e.res);
        chk("w8_flags_cnzvi", {c8, n8, z8, v8, il8}, {e.c, e.n, e.z, e.v, e.il});
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst16 && ov16 && or16) begin
      if (q16.size() == 0) chk("w16_unexpected_out", 1, 0);
      else begin
        e = q16.pop_front();
        chk("w16_result", res16, e.res);
        chk("w16_flags_cnzvi", {c16, n16, z16, v16, il16}, {e.c, e.n, e.z, e.v, e.il});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t        dummy;
    int          n;
    logic [12:0] snap;
    dummy.res = 0; {dummy.c, dummy.n, dummy.z, dummy.v, dummy.il} = '0;

    repeat (3) @(negedge clk);
    chk("rst_out_valid8", ov8, 0);
    chk("rst_result8", res8, 0);
    chk("rst_flags8", {c8, n8, z8, v8, il8}, 0);
    chk("rst_out_valid16", ov16, 0);
    rst8 = 0; rst16 = 0;
    @(negedge clk);
    chk("rst_in_ready8", ir8, 1);
    chk("rst_in_ready16", ir16, 1);

    // Directed sequence, WIDTH=8; flags are {C,N,Z,V,ILL}
    dir(8, 4'h0, 'hFF, 'h01, 'h00, 5'b10100);
    dir(8, 4'h8, 'h00, 'h00, 'h01, 5'b00000);
    dir(8, 4'h1, 'h80, 'h01, 'h7F, 5'b10010);
    dir(8, 4'hD, 'h05, 'h05, 'h05, 5'b10100);
    dir(8, 4'h9, 'h10, 'h01, 'h0F, 5'b10000);
    dir(8, 4'hB, 'h01, 'h00, 'h80, 5'b11000);
    dir(8, 4'hC, 'h80, 'h00, 'hC0, 5'b01000);
    dir(8, 4'hA, 'h80, 'h00, 'h01, 5'b10000);
    dir(8, 4'h0, 'hFF, 'h01, 'h00, 5'b10100);
    dir(8, 4'hF, 'h12, 'h34, 'h00, 5'b00101);
    dir(8, 4'h8, 'h00, 'h00, 'h01, 5'b00000);
    drain(8);

    // Stall: consumer holds off while three ops are offered
    stall8 = 1;
    @(negedge clk);
    @(negedge clk);
    iv8 = 1; op8 = 4'h0; a8 = 8'h11; b8 = 8'h22;
    chk("stall_accept1", ir8, 1);
    push(8, 4'h0, 'h11, 'h22, 1'b0, dummy);
    @(negedge clk);
    op8 = 4'h6; a8 = 8'h81; b8 = 8'h00;
    chk("stall_accept2", ir8, 1);
    push(8, 4'h6, 'h81, 'h00, 1'b0, dummy);
    @(negedge clk);
    op8 = 4'hE; a8 = 8'h00; b8 = 8'h5A;
    chk("stall_in_ready_low", ir8, 0);
    chk("stall_out_valid", ov8, 1);
    snap = {res8, c8, n8, z8, v8, il8};
    repeat (3) begin
      @(negedge clk);
      chk("stall_in_ready_held", ir8, 0);
      chk("stall_outputs_stable", {res8, c8, n8, z8, v8, il8}, snap);
    end
    stall8 = 0;
    n = 0;
    @(negedge clk);
    while (!ir8 && n < 10) begin @(negedge clk); n++; end
    chk("stall_release_accept", ir8, 1);
    push(8, 4'hE, 'h00, 'h5A, 1'b0, dummy);
    chk("release_out_valid1", ov8, 1);
    @(posedge clk);
    #1 iv8 = 0;
    @(negedge clk);
    chk("release_out_valid2", ov8, 1);
    @(negedge clk);
    chk("release_out_valid3", ov8, 1);
    drain(8);

    // Random traffic with random back-pressure, WIDTH=8
    bp8 = 1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(negedge clk);
      issue(8, 4'($urandom_range(0, 15)), longint'($urandom_range(0, 255)),
            longint'($urandom_range(0, 255)), 1'b0, dummy);
    end
    drain(8);
    bp8 = 0;

    // WIDTH=16 directed
    dir(16, 4'h0, 'h7FFF, 'h0001, 'h8000, 5'b01010);
    dir(16, 4'h0, 'hFFFF, 'h0001, 'h0000, 5'b10100);
    drain(16);

    // Reset with two ops in flight: both discarded, carry cleared
    stall16 = 1;
    @(negedge clk);
    @(negedge clk);
    iv16 = 1; op16 = 4'h0; a16 = 16'hFFFF; b16 = 16'h0001;
    @(negedge clk);
    op16 = 4'h0; a16 = 16'hFFFF; b16 = 16'h0002;
    @(negedge clk);
    iv16 = 0;
    rst16 = 1;
    @(negedge clk);
    chk("midrst_out_valid", ov16, 0);
    chk("midrst_result", res16, 0);
    rst16 = 0;
    q16.delete();
    cf16 = 0;
    stall16 = 0;
    @(negedge clk);
    chk("midrst_in_ready", ir16, 1);
    repeat (4) begin
      @(negedge clk);
      chk("midrst_no_output", ov16, 0);
    end
    dir(16, 4'h8, 'h0000, 'h0000, 'h0000, 5'b00100);
    drain(16);

    // Random traffic, WIDTH=16
    bp16 = 1;
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      issue(16, 4'($urandom_range(0, 15)), longint'($urandom_range(0, 65535)),
            longint'($urandom_range(0, 65535)), 1'b0, dummy);
    end
    drain(16);
    bp16 = 0;
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
